// File: rtl/sprite_sched_pkg.sv
// Shared state, position-record types and limits for the sprite scheduler.
package sprite_sched_pkg;

   localparam int MAX_SPR = 8;
   localparam int POS_W   = 10;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACTIVE,
      DONE
   } spr_state_t;

   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
      logic             vis;
   } spr_pos_t;

endpackage

// File: rtl/sprite_sched_slot.sv
// One sprite's line scheduler: start-line match, start pulse (1 cycle after match), line count.
// No backpressure; follows the timing generator every cycle.
module sprite_sched_slot
   import sprite_sched_pkg::*;
#(
   parameter int CORDW      = POS_W,
   parameter int H_RES      = 640,
   parameter int V_RES_FULL = 525,
   parameter int SPR_LINES  = 80
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CORDW-1:0] sx,
   input  logic [CORDW-1:0] sy,
   input  logic             frame,
   input  logic [CORDW-1:0] y,
   input  logic             vis,
   input  logic             nxt_vis,
   output logic             start,
   output logic             active
);

   localparam int               CNTW     = $clog2(SPR_LINES + 1);
   localparam logic [CORDW-1:0] H_END    = CORDW'(H_RES);
   localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_RES_FULL - 1);
   localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(SPR_LINES - 1);

   spr_state_t       state, state_nxt;
   logic [CNTW-1:0]  cnt, cnt_nxt;
   logic             start_nxt;
   logic [CORDW-1:0] ys;
   logic             y_ok;
   logic             line_end;

   // Start one line early so the sprite can prefetch during blanking.
   assign ys       = (y == '0) ? V_LAST : y - CORDW'(1);
   assign y_ok     = (32'(y) < V_RES_FULL);
   assign line_end = (sx == H_END);
   assign active   = (state == ACTIVE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      start_nxt = 1'b0;
      if (frame) begin
         state_nxt = nxt_vis ? WAIT : IDLE;
      end else begin
         case (state)
            WAIT: begin
               if (line_end && y_ok && vis && (sy == ys)) begin
                  state_nxt = ACTIVE;
                  cnt_nxt   = '0;
                  start_nxt = 1'b1;
               end
            end
            ACTIVE: begin
               if (line_end) begin
                  if (cnt == CNT_LAST) state_nxt = DONE;
                  else                 cnt_nxt   = cnt + CNTW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         start <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         start <= start_nxt;
      end
   end

endmodule

// File: rtl/sprite_sched.sv
// Sprite scheduler: shadow/active position tables, per-sprite slots, priority pixel merge (1-cycle latency).
// No backpressure. Define SPRITE_SCHED_COLLIDE_EN to add the per-frame collision register.
module sprite_sched
   import sprite_sched_pkg::*;
#(
   parameter int NUM_SPR    = 4,
   parameter int CORDW      = POS_W,
   parameter int H_RES      = 640,
   parameter int V_RES_FULL = 525,
   parameter int SPR_LINES  = 80
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CORDW-1:0]         sx,
   input  logic [CORDW-1:0]         sy,
   input  logic                     de,
   input  logic                     frame,
   input  logic                     wr_en,
   input  logic [2:0]               wr_idx,
   input  logic [CORDW-1:0]         wr_x,
   input  logic [CORDW-1:0]         wr_y,
   input  logic                     wr_vis,
   output logic [NUM_SPR-1:0]       spr_start,
   output logic [NUM_SPR*CORDW-1:0] spr_x,
   input  logic [NUM_SPR-1:0]       spr_pix,
   output logic                     pix_on,
   output logic [2:0]               pix_idx
`ifdef SPRITE_SCHED_COLLIDE_EN
   ,
   output logic [NUM_SPR-1:0]       collide
`endif
);

   spr_pos_t                     shadow [NUM_SPR];
   spr_pos_t                     active [NUM_SPR];
   spr_pos_t                     nxt    [NUM_SPR];
   spr_pos_t                     wr_pos;
   logic [NUM_SPR-1:0]           act_mask;
   logic [NUM_SPR-1:0]           cand;
   logic                         win_vld;
   logic [$clog2(MAX_SPR)-1:0]   win_idx;

   assign wr_pos = '{x: wr_x, y: wr_y, vis: wr_vis};

   // nxt is the shadow as it will be after this cycle's write, so a write
   // landing on the frame pulse is committed straight through.
   always_comb begin
      for (int i = 0; i < NUM_SPR; i++) begin
         nxt[i] = (wr_en && (wr_idx == 3'(i))) ? wr_pos : shadow[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SPR; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SPR; i++) begin
            shadow[i] <= nxt[i];
            if (frame) active[i] <= nxt[i];
         end
      end
   end

   for (genvar i = 0; i < NUM_SPR; i++) begin : g_slot
      assign spr_x[i*CORDW +: CORDW] = active[i].x;

      sprite_sched_slot #(
         .CORDW      (CORDW),
         .H_RES      (H_RES),
         .V_RES_FULL (V_RES_FULL),
         .SPR_LINES  (SPR_LINES)
      ) u_slot (
         .clk     (clk),
         .rst     (rst),
         .sx      (sx),
         .sy      (sy),
         .frame   (frame),
         .y       (active[i].y),
         .vis     (active[i].vis),
         .nxt_vis (nxt[i].vis),
         .start   (spr_start[i]),
         .active  (act_mask[i])
      );
   end

   // Lowest index wins, so scan downward and let later hits overwrite.
   always_comb begin
      cand    = spr_pix & act_mask;
      win_vld = 1'b0;
      win_idx = '0;
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
         if (cand[i]) begin
            win_vld = 1'b1;
            win_idx = 3'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_on  <= 1'b0;
         pix_idx <= '0;
      end else begin
         pix_on  <= de & win_vld;
         pix_idx <= win_vld ? win_idx : '0;
      end
   end

`ifdef SPRITE_SCHED_COLLIDE_EN
   logic [NUM_SPR-1:0] sticky;
   logic [NUM_SPR-1:0] hit;

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_SPR; i++) begin
         hit[i] = de && spr_pix[i] && ((spr_pix & ~(NUM_SPR'(1) << i)) != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky  <= '0;
         collide <= '0;
      end else if (frame) begin
         collide <= sticky | hit;
         sticky  <= '0;
      end else begin
         sticky  <= sticky | hit;
      end
   end
`endif

endmodule

// File: doc/sprite_sched.md
Name: sprite_sched

Overview:
- Schedules up to NUM_SPR hardware sprite instances sharing one display timing generator.
- Holds a shadow position table written by the game/control logic; commits it to the active table at each frame boundary.
- Generates each sprite's start pulse in the blanking of the line before its first line, tracks drawn lines, and priority-merges sprite pixel outputs into one colour index.
- Sits between display_timings and the sprite instances in the top level.

Parameters:
- NUM_SPR, 4, number of scheduled sprites (1-8)
- CORDW, 10, screen coordinate width in bits
- H_RES, 640, active width; start pulse issued at sx == H_RES
- V_RES_FULL, 525, total lines including blanking
- SPR_LINES, 80, screen lines per sprite (HEIGHT*SCALE_Y)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- sx  in  CORDW  horizontal screen position
- sy  in  CORDW  vertical screen position
- de  in  1  display enable
- frame  in  1  one-cycle pulse at sx==0, sy==0
- wr_en  in  1  shadow table write strobe
- wr_idx  in  3  sprite index written
- wr_x  in  CORDW  new x position
- wr_y  in  CORDW  new y position
- wr_vis  in  1  new visible flag
- spr_start  out  NUM_SPR  per-sprite start pulse
- spr_x  out  NUM_SPR*CORDW  active x per sprite, sprite i at [i*CORDW +: CORDW]
- spr_pix  in  NUM_SPR  pixel-on flags from sprite instances
- pix_on  out  1  any sprite pixel on during de
- pix_idx  out  3  index of winning sprite

Behaviour:
- Reset (synchronous, active-high; all outputs registered):
  - spr_start=0, pix_on=0, pix_idx=0, spr_x=0.
  - Shadow and active tables cleared; all visible flags 0.
  - All per-sprite FSMs go to IDLE.
  - Reset mid-frame aborts any ACTIVE sprite; no start pulse appears until the frame pulse after reset release.
- Shadow writes:
  - wr_en with wr_idx < NUM_SPR updates the shadow entry next cycle.
  - wr_idx >= NUM_SPR is ignored.
- Commit:
  - On frame, active table <= shadow table.
  - If wr_en coincides with frame, the new write value is committed (write-through for that entry).
  - Writes never alter the active table mid-frame.
- Start line per sprite:
  - ys = (y == 0) ? V_RES_FULL-1 : y-1, computed with CORDW-bit compare, no overflow.
  - A sprite with y >= V_RES_FULL never starts.
- Per-sprite FSM:
  - IDLE -> WAIT on frame if the committed vis=1; otherwise stay IDLE.
  - WAIT -> ACTIVE when sy==ys and sx==H_RES. spr_start[i] is registered and high exactly one cycle, the cycle after the match (1-cycle latency). Line counter loads 0.
  - ACTIVE: counter increments at each sx==H_RES after entry. -> DONE when counter reaches SPR_LINES-1 at sx==H_RES.
  - DONE -> WAIT on frame if vis=1, else -> IDLE.
  - frame in ACTIVE (sprite wraps past the last line) -> WAIT or IDLE per committed vis. A wrapped sprite (y==0, ys=V_RES_FULL-1) therefore starts on the final line of the previous frame; it is WAIT from that frame pulse onward.
  - Hidden sprites never pulse spr_start.
- Pixel merge:
  - Registered, 1-cycle latency from spr_pix.
  - Lowest set index i among spr_pix & ACTIVE-state mask wins.
  - pix_on = de & (winner exists); pix_idx = winner, else 0.
- spr_x[i] is driven from the active table only; it is stable for a whole frame.

Optional Feature:
- Macro SPRITE_SCHED_COLLIDE_EN.
- Defined:
  - Adds output collide, NUM_SPR-bit.
  - collide[i] is a sticky set when spr_pix[i] and any other spr_pix[j] are both high while de=1.
  - Snapshot to a collide output register on frame, then the sticky bits clear. Software therefore reads the previous frame's collisions all frame.
  - Reset clears both.
- Undefined:
  - No port and no logic.

Decomposition:
- Package sprite_sched_pkg:
  - typedef enum {IDLE, WAIT, ACTIVE, DONE} spr_state_t.
  - typedef struct packed {x, y, vis} spr_pos_t with CORDW fields.
  - MAX_SPR=8 constant.
- One sub-module, sprite_sched_slot: the per-sprite FSM, line counter and start-line comparator, instantiated NUM_SPR times via generate.
- The top holds the tables and the priority merge.

Test Plan:
- Reset then write idx0 x=280 y=200 vis=1, frame -> spr_start[0] high one cycle at sy=199 sx=641; FSM DONE after line 279; no other start pulses.
- idx1 y=0 vis=1 -> start pulse at sy=524 sx=641 of the prior frame; y=600 -> no pulse ever.
- Write idx0 y=100 mid-frame (sy=300) -> current frame unaffected; next frame starts at sy=99. A write coincident with frame commits immediately.
- spr_pix=4'b0110 with de=1 and sprites 1,2 ACTIVE -> next cycle pix_on=1, pix_idx=1; de=0 -> pix_on=0.
- Assert rst at sy=230 while sprite 0 is ACTIVE -> all outputs 0 next cycle; no start until after the following frame pulse.
- COLLIDE_EN: overlap of sprites 0 and 2 for one pixel -> after frame, collide=4'b0101; next frame with no overlap -> 0.
